sdram_rd_stream: RTL and testbench

- Read-only streaming master for one arbiter channel (S1 or S2 port) on sdramclk.
- Given a start word address and a word count, it issues burst read commands of at most BURST words. A burst never crosses a BURST-aligned boundary.
- Returned beats are collected into a first-word-fall-through FIFO for a local consumer, e.g. a video line fetcher.
- Commands are issued only when the FIFO has guaranteed room for the whole burst, so the FIFO can never overflow.

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_sync_fifo.sv | 52 +++++
 rtl/sdram_rd_stream.sv | 176 +++++++++++++++++
 tb/tb_sdram_rd_stream.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM channel masters.
//   SDRAM_AW / SDRAM_DW : word address and data widths of an arbiter channel
//   CMD_RD / CMD_WR     : command encodings on the cmd port
//   rd_state_t          : state encoding of the read-stream controller
package sdram_pkg;

  localparam int   SDRAM_AW = 23;
  localparam int   SDRAM_DW = 32;
  localparam logic CMD_RD   = 1'b0;
  localparam logic CMD_WR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_DRAIN   = 3'd4
  } rd_state_t;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   sdramclk, rst_n : clock, asynchronous active-low reset
//   push, wdata     : write strobe and data (dropped when full without a pop)
//   pop             : remove head; ignored while empty
//   flush           : discard all contents; wins over push
//   rdata           : current head, valid while empty=0
//   empty, level    : status, level in words (0 .. 2**AW)
module sdram_sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          sdramclk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr, rptr;
  logic          full, do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wptr - rptr;
  assign empty   = (level == '0);
  assign full    = level[AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge sdramclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge sdramclk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sdram_rd_stream.sv
// Read-only streaming master for one SDRAM arbiter channel.
// Splits a (start_addr, word_count) transfer into burst reads that never
// cross a BURST-aligned boundary and collects the returned beats in a FWFT
// FIFO. A burst is only requested once the FIFO has room for every word
// already requested plus this burst, so the FIFO cannot overflow.
//   control : start, start_addr, word_count, abort -> busy, done
//   command : cmd, cmd_en, addr, len  <- cmd_ready
//   beats   : rdata, rvalid
//   consumer: rd_en -> rd_data, rd_empty, fifo_level
//
// state      | meaning
// IDLE       | waiting for start
// ISSUE      | deciding the next burst, waiting for FIFO credit
// REQ        | cmd_en held until the arbiter accepts
// WAIT_RX    | all bursts requested, collecting remaining beats
// DRAIN      | aborted: FIFO cleared, swallowing outstanding beats
module sdram_rd_stream
  import sdram_pkg::*;
#(
  parameter int FIFO_AW = 6,
  parameter int BURST   = 16
) (
  input  logic                sdramclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SDRAM_AW-1:0] start_addr,
  input  logic [15:0]         word_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                cmd,
  output logic                cmd_en,
  output logic [SDRAM_AW-1:0] addr,
  output logic [3:0]          len,
  input  logic                cmd_ready,
  input  logic [SDRAM_DW-1:0] rdata,
  input  logic                rvalid,
  input  logic                rd_en,
  output logic [SDRAM_DW-1:0] rd_data,
  output logic                rd_empty,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam int LB = $clog2(BURST);
  localparam int CW = FIFO_AW + 2;

  rd_state_t           state;
  logic [SDRAM_AW-1:0] cur_addr;
  logic [15:0]         issue_rem;
  logic [15:0]         rx_rem;
  logic [CW-1:0]       outstanding;
  logic                abort_pend;

  logic [4:0]    to_bound;
  logic [4:0]    blen;
  logic [CW-1:0] space;
  logic          credit_ok;
  logic          beat;
  logic          wr_fifo;
  logic          reserve;
  logic          flush;

  assign cmd = CMD_RD;

  assign to_bound  = 5'(BURST) - 5'(cur_addr[LB-1:0]);
  assign blen      = (issue_rem < 16'(to_bound)) ? issue_rem[4:0] : to_bound;
  assign space     = CW'(2**FIFO_AW) - CW'(fifo_level) - outstanding;
  assign credit_ok = (space >= CW'(blen));

  // Beats are counted against outstanding in every active state but only
  // stored while the transfer is live.
  assign beat    = rvalid && (state != ST_IDLE);
  assign wr_fifo = rvalid && (state == ST_ISSUE || state == ST_REQ || state == ST_WAIT_RX);
  assign reserve = (state == ST_ISSUE) && !abort && (issue_rem != 16'd0) && credit_ok;
  assign flush   = (state == ST_DRAIN);

  sdram_sync_fifo #(
    .DW (SDRAM_DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .sdramclk (sdramclk),
    .rst_n    (rst_n),
    .push     (wr_fifo),
    .wdata    (rdata),
    .pop      (rd_en),
    .flush    (flush),
    .rdata    (rd_data),
    .empty    (rd_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge sdramclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      issue_rem   <= '0;
      rx_rem      <= '0;
      outstanding <= '0;
      abort_pend  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_en      <= 1'b0;
      addr        <= '0;
      len         <= '0;
    end else begin
      done <= 1'b0;

      // Credit is reserved at request time; a beat in the same cycle nets out.
      outstanding <= outstanding + (reserve ? CW'(blen) : CW'(0)) - (beat ? CW'(1) : CW'(0));
      if (wr_fifo) rx_rem <= rx_rem - 16'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (word_count == 16'd0) begin
              done <= 1'b1;
            end else begin
              cur_addr   <= start_addr;
              issue_rem  <= word_count;
              rx_rem     <= word_count;
              abort_pend <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (issue_rem == 16'd0) begin
            state <= ST_WAIT_RX;
          end else if (credit_ok) begin
            addr   <= cur_addr;
            len    <= 4'(blen - 5'd1);
            cmd_en <= 1'b1;
            state  <= ST_REQ;
          end
        end

        // cur_addr and issue_rem are frozen here, so blen still matches len.
        ST_REQ: begin
          if (cmd_ready) begin
            cmd_en     <= 1'b0;
            cur_addr   <= cur_addr + SDRAM_AW'(blen);
            issue_rem  <= issue_rem - 16'(blen);
            abort_pend <= 1'b0;
            state      <= (abort_pend || abort) ? ST_DRAIN : ST_ISSUE;
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end

        ST_WAIT_RX: begin
          if (rx_rem == 16'd0 || (rx_rem == 16'd1 && wr_fifo)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (abort) begin
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (outstanding == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rd_stream.sv
// Scoreboard bench for sdram_rd_stream: a memory/arbiter model answers the
// DUT's commands, a reference model predicts commands and the data stream,
// and a negedge monitor compares everything the DUT presents.
module tb_sdram_rd_stream;

  logic        sdramclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [22:0] start_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        busy, done, cmd, cmd_en;
  logic [22:0] addr;
  logic [3:0]  len;
  logic        cmd_ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic [6:0]  fifo_level;

  always #5 sdramclk = ~sdramclk;

  sdram_rd_stream #(.FIFO_AW(6), .BURST(16)) dut (
    .sdramclk   (sdramclk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .cmd        (cmd),
    .cmd_en     (cmd_en),
    .addr       (addr),
    .len        (len),
    .cmd_ready  (cmd_ready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_empty   (rd_empty),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [22:0] a;
    logic [3:0]  l;
  } cmd_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data[$];
  cmd_t        exp_cmd[$];
  logic [31:0] beat_q[$];

  int tb_out = 0, acc_cnt = 0, acc_words = 0, done_cnt = 0, busy_seen = 0;
  int arb_delay = -1;
  int stall_limit = -1;
  int cons_mode = 1;
  int wait_cnt, drv_acc, cur_delay;

  logic        prev_en = 1'b0;
  logic        prev_acc = 1'b0;
  logic [22:0] prev_addr;
  logic [3:0]  prev_len;

  function automatic logic [31:0] mem_word(logic [22:0] a);
    return ({9'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: the word stream is simply consecutive addresses; bursts
  // are carved greedily up to the next 16-word boundary.
  task automatic expect_xfer(input logic [22:0] a, input int n);
    logic [22:0] p;
    int rem, room, b;
    cmd_t c;
    for (int i = 0; i < n; i++) exp_data.push_back(mem_word(a + 23'(i)));
    p = a;
    rem = n;
    while (rem > 0) begin
      room = 16 - int'(p[3:0]);
      b = (rem < room) ? rem : room;
      c.a = p;
      c.l = 4'(b - 1);
      exp_cmd.push_back(c);
      p = p + 23'(b);
      rem -= b;
    end
  endtask

  // Arbiter, memory and consumer model, driven just after each rising edge.
  initial begin
    cmd_ready = 1'b0; rvalid = 1'b0; rdata = '0; rd_en = 1'b0;
    wait_cnt = 0; drv_acc = 0; cur_delay = 0;
    forever begin
      @(posedge sdramclk); #1;
      cmd_ready = 1'b0;
      rvalid = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
        rd_en = 1'b0;
      end else begin
        if (cmd_en && !(stall_limit >= 0 && drv_acc >= stall_limit)) begin
          if (wait_cnt >= ((arb_delay >= 0) ? arb_delay : cur_delay)) begin
            cmd_ready = 1'b1;
            drv_acc++;
            wait_cnt = 0;
            cur_delay = $urandom_range(0, 3);
            for (int i = 0; i <= int'(len); i++) beat_q.push_back(mem_word(addr + 23'(i)));
          end else begin
            wait_cnt++;
          end
        end
        if (beat_q.size() > 0 && $urandom_range(0, 9) < 7) begin
          rvalid = 1'b1;
          rdata = beat_q.pop_front();
        end
        case (cons_mode)
          0: rd_en = 1'b0;
          1: rd_en = 1'b1;
          default: rd_en = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Monitor: everything sampled mid-cycle describes the coming edge.
  always @(negedge sdramclk) begin
    cmd_t c;
    logic [31:0] e;
    if (!rst_n) begin
      prev_en = 1'b0;
      prev_acc = 1'b0;
      tb_out = 0;
    end else begin
      if (prev_en && !prev_acc)
        chk(cmd_en && addr == prev_addr && len == prev_len, "cmd_hold",
            {cmd_en, addr, len}, {1'b1, prev_addr, prev_len});
      if (cmd_en && cmd_ready) begin
        acc_cnt++;
        acc_words += int'(len) + 1;
        tb_out += int'(len) + 1;
        if (exp_cmd.size() == 0) begin
          chk(1'b0, "cmd_extra", {addr, len}, 0);
        end else begin
          c = exp_cmd.pop_front();
          chk(addr == c.a && len == c.l, "cmd_addr_len", {addr, len}, {c.a, c.l});
        end
        chk(cmd == 1'b0, "cmd_read", cmd, 0);
        chk(int'(fifo_level) + tb_out <= 64, "cmd_credit", int'(fifo_level) + tb_out, 64);
      end
      if (rvalid) tb_out--;
      if (rd_en && !rd_empty) begin
        if (exp_data.size() == 0) begin
          chk(1'b0, "rd_extra", rd_data, 0);
        end else begin
          e = exp_data.pop_front();
          chk(rd_data == e, "rd_data", rd_data, e);
        end
      end
      if (done) done_cnt++;
      if (busy) busy_seen++;
      prev_en = cmd_en;
      prev_acc = cmd_en && cmd_ready;
      prev_addr = addr;
      prev_len = len;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sdramclk);
    #1;
  endtask

  task automatic start_xfer(input logic [22:0] a, input int n);
    expect_xfer(a, n);
    cyc(1);
    start = 1'b1; start_addr = a; word_count = 16'(n);
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int c = 0;
    while (busy && c < max) begin cyc(1); c++; end
    chk(!busy, "idle_timeout", busy, 0);
  endtask

  task automatic wait_drain(input int max);
    int c = 0;
    while ((exp_data.size() != 0 || !rd_empty) && c < max) begin cyc(1); c++; end
    chk(exp_data.size() == 0 && rd_empty, "drain_timeout", exp_data.size(), 0);
  endtask

  task automatic run_full(input logic [22:0] a, input int n, input int ncmd);
    int d0, a0;
    d0 = done_cnt;
    a0 = acc_cnt;
    start_xfer(a, n);
    wait_idle(3000);
    wait_drain(3000);
    chk(done_cnt - d0 == 1, "done_once", done_cnt - d0, 1);
    chk(exp_cmd.size() == 0, "cmds_issued", exp_cmd.size(), 0);
    if (ncmd >= 0) chk(acc_cnt - a0 == ncmd, "cmd_count", acc_cnt - a0, ncmd);
  endtask

  task automatic check_reset_vals(input string name);
    chk(!cmd_en && !cmd && addr == 23'd0 && len == 4'd0 && !busy && !done &&
        rd_empty && fifo_level == 7'd0, name,
        {cmd_en, cmd, busy, done, rd_empty, fifo_level},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, a0, w0, b0, c;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; abort = 1'b0;
    cyc(3);
    check_reset_vals("reset_vals");
    rst_n = 1'b1;
    cyc(2);

    // Aligned and unaligned transfers, consumer always popping
    cons_mode = 1;
    run_full(23'h000100, 40, 3);
    run_full(23'h00000D, 20, 3);

    // Random transfers with a random consumer
    cons_mode = 2;
    for (int i = 0; i < 6; i++)
      run_full(23'($urandom_range(0, 23'h7FFFFF)), $urandom_range(1, 100), -1);

    // Zero count
    d0 = done_cnt; a0 = acc_cnt; b0 = busy_seen;
    start_xfer(23'h000040, 0);
    cyc(6);
    chk(done_cnt - d0 == 1, "zero_done", done_cnt - d0, 1);
    chk(acc_cnt == a0 && busy_seen == b0, "zero_no_cmd", acc_cnt - a0 + busy_seen - b0, 0);

    // Start while busy is ignored
    d0 = done_cnt;
    expect_xfer(23'h000300, 50);
    cyc(1);
    start = 1'b1; start_addr = 23'h000300; word_count = 16'd50;
    cyc(1);
    start = 1'b0;
    cyc(4);
    start = 1'b1; start_addr = 23'h000555; word_count = 16'd7;
    cyc(1);
    start = 1'b0;
    wait_idle(3000);
    wait_drain(3000);
    chk(done_cnt - d0 == 1, "busy_start_done", done_cnt - d0, 1);
    chk(exp_cmd.size() == 0, "busy_start_cmds", exp_cmd.size(), 0);

    // Back-pressure across the address wrap
    cons_mode = 0;
    w0 = acc_words; d0 = done_cnt;
    start_xfer(23'h7FFFC0, 128);
    cyc(300);
    chk(fifo_level == 7'd64, "bp_level", fifo_level, 64);
    chk(acc_words - w0 == 64, "bp_requested", acc_words - w0, 64);
    chk(busy == 1'b1, "bp_busy", busy, 1);
    cons_mode = 1;
    wait_idle(3000);
    wait_drain(3000);
    chk(done_cnt - d0 == 1, "bp_done", done_cnt - d0, 1);

    // Arbiter stall with abort during the stall
    cons_mode = 0; arb_delay = 20;
    d0 = done_cnt; a0 = acc_cnt;
    start_xfer(23'h000400, 40);
    c = 0;
    while (!cmd_en && c < 50) begin cyc(1); c++; end
    chk(cmd_en, "stall_cmd_en", cmd_en, 1);
    cyc(8);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk(cmd_en, "abort_cmd_held", cmd_en, 1);
    wait_idle(1000);
    cyc(2);
    chk(rd_empty && fifo_level == 7'd0, "abort_flushed", fifo_level, 0);
    chk(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);
    chk(acc_cnt - a0 == 1, "abort_one_cmd", acc_cnt - a0, 1);
    chk(tb_out == 0 && beat_q.size() == 0, "abort_beats_done", tb_out, 0);
    exp_data.delete();
    exp_cmd.delete();
    arb_delay = -1;

    // Reset while a request is pending and the FIFO holds 10 words
    stall_limit = drv_acc + 1;
    start_xfer(23'h000206, 40);
    c = 0;
    while (!(fifo_level == 7'd10 && cmd_en) && c < 300) begin cyc(1); c++; end
    chk(fifo_level == 7'd10 && cmd_en, "rst_setup", {cmd_en, fifo_level}, {1'b1, 7'd10});
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_burst");
    exp_data.delete();
    exp_cmd.delete();
    beat_q.delete();
    cyc(2);
    stall_limit = -1;
    rst_n = 1'b1;
    cyc(2);

    // Recovery transfer wrapping the address space
    cons_mode = 2;
    run_full(23'h7FFFF5, 30, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
